multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Multi-precision add/subtract controller.
- Sequences one shared N-bit word adder over WORDS cycles, least-significant word first, and chains the carry between words through a carry register.
- Produces an (N*WORDS)-bit result with unsigned carry-out and signed overflow.
- Sits between a requester (start/done pulse handshake) and the word-adder datapath; lets wide arithmetic reuse a narrow adder.

Parameters:
- N, 8, width of one word and of the shared adder.
- WORDS, 4, number of words per operand (minimum 2).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request pulse; accepted only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a_in  input  N*WORDS  operand A; sampled with start.
- b_in  input  N*WORDS  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, result valid.
- sum  output  N*WORDS  result.
- cout  output  1  carry out of top word (for sub: 1 = no borrow, i.e. a >= b unsigned).
- overflow  output  1  signed two's-complement overflow of the full-width operation.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state = IDLE; sum, cout, overflow, done, busy, word index and carry register all 0. Reset overrides start in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch a_in, b_in and sub; set idx=0; set carry register = sub; go to RUN. start=0 keeps IDLE.
- RUN (one word per cycle):
  - Word datapath: word_x = A[idx], word_y = B[idx] XOR {N{sub_latched}}; word result = word_x + word_y + carry.
  - Write the word result to sum[idx*N +: N].
  - carry <= carry-out of the word; idx <= idx+1.
  - When idx == WORDS-1: register cout = final carry; register overflow = (xt & yt & ~st) | (~xt & ~yt & st), where xt, yt, st are the MSBs of the top word's word_x, effective word_y and word result. Then go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Latency: start sampled at edge k → words written at edges k+1..k+WORDS → done high during the cycle after edge k+WORDS. Total start-to-done = WORDS+1 cycles; 5 cycles at the defaults.
- Throughput: a new start is accepted at earliest in the IDLE cycle after DONE. Minimum start spacing is WORDS+2 cycles.
- start while busy (RUN or DONE): ignored, no queuing, latched operands unchanged.
- sum words update progressively during RUN. sum is defined only from done onward. sum, cout and overflow hold until the next accepted start's RUN overwrites them. cout and overflow change only at the last RUN edge.
- Input changes after acceptance: no effect on the operation in progress.
- reset mid-RUN or in DONE: abort, all outputs to reset values, no done pulse.
- Arithmetic is modulo 2^(N*WORDS). Carry and overflow never widen sum.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default N/WORDS constants.
- Index width is $clog2(WORDS), declared locally.
- One sub-module, word_adder_cin: combinational N-bit x+y+cin with outputs s, cout and the word-level signed overflow term. The sequencer instantiates it once and owns all registers.

Test Plan (N=8, WORDS=4):
- Add with internal carry: a=0x000000FF, b=0x00000001, sub=0 → sum=0x00000100, cout=0, overflow=0; done exactly 5 cycles after start, single-cycle pulse.
- Full carry ripple: a=0xFFFFFFFF + b=0x00000001 → sum=0x00000000, cout=1, overflow=0. Then a=0x7FFFFFFF + b=0x00000001 → sum=0x80000000, cout=0, overflow=1.
- Subtract: a=0x00000000 − b=0x00000001 → sum=0xFFFFFFFF, cout=0, overflow=0. Then a=0x80000000 − b=0x00000001 → sum=0x7FFFFFFF, cout=1, overflow=1.
- start pulsed in RUN with different operands (0x11111111 + 0x22222222), with the first op 0x12345678 + 0x11111111 → first result 0x23456789 unaffected, busy stays 1, no second done.
- reset asserted on the 2nd RUN cycle → next edge busy=0, done=0, sum=0, cout=0, overflow=0. A subsequent start (0x00000001 + 0x00000001) → sum=0x00000002 after 5 cycles.
- Back-to-back: start asserted the first IDLE cycle after done → accepted. Second result is correct and independent of the first op's final carry.

Source files
------------

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
// Holds the controller state encoding and the default word geometry.
package multiword_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF     = 8;
  localparam int WORDS_DEF = 4;

endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// word_adder_cin: combinational N-bit adder with carry-in.
// Ports:
//   x, y  : N-bit word operands (y already conditioned for subtract)
//   cin   : carry into bit 0
//   s     : N-bit word sum
//   cout  : carry out of bit N-1
//   ovf   : signed overflow of this word, valid when it is the top word
module word_adder_cin #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  logic [N:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
  assign s    = full[N-1:0];
  assign cout = full[N];

  // Two's-complement overflow: both inputs share a sign that the result lacks.
  assign ovf  = (x[N-1] & y[N-1] & ~s[N-1]) | (~x[N-1] & ~y[N-1] & s[N-1]);

endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: wide add/subtract built from one shared N-bit
// word adder, stepped least-significant word first over WORDS cycles.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, sub      : request pulse (taken only in IDLE), 0 = add, 1 = subtract
//   a_in, b_in      : N*WORDS-bit operands, sampled with start
//   busy            : high while RUN or DONE
//   done            : one-cycle pulse, result valid
//   sum             : N*WORDS-bit result (modulo 2^(N*WORDS))
//   cout            : carry out of the top word (subtract: 1 = no borrow)
//   overflow        : signed overflow of the full-width operation
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [N*WORDS-1:0] a_in,
  input  logic [N*WORDS-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [N*WORDS-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sub_q;
  logic [IW-1:0] idx;
  logic          carry;

  logic [31:0]   wbase;
  logic [N-1:0]  word_x;
  logic [N-1:0]  word_y;
  logic [N-1:0]  word_s;
  logic          word_c;
  logic          word_v;

  // Word select: current word of A, and B inverted when subtracting
  // (a - b = a + ~b + 1, the +1 coming from the carry register seed).
  assign wbase  = 32'(idx) * 32'(N);
  assign word_x = a_q[wbase +: N];
  assign word_y = b_q[wbase +: N] ^ {N{sub_q}};

  word_adder_cin #(.N(N)) u_word_adder (
    .x    (word_x),
    .y    (word_y),
    .cin  (carry),
    .s    (word_s),
    .cout (word_c),
    .ovf  (word_v)
  );

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && start) begin
      a_q   <= a_in;
      b_q   <= b_in;
      sub_q <= sub;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= '0;
            carry <= sub;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[wbase +: N] <= word_s;
          carry           <= word_c;
          idx             <= idx + 1'b1;
          if (idx == LAST) begin
            cout     <= word_c;
            overflow <= word_v;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (N=8, WORDS=4).
module tb_multiword_add_sequencer;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;
  localparam int LAT   = WORDS + 1;

  typedef struct {
    bit [W-1:0] sum;
    bit         cout;
    bit         ovf;
    int         cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic prev_done = 1'b0;

  multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic exp_t model(input bit [W-1:0] a, input bit [W-1:0] b, input bit s);
    exp_t   e;
    longint ua, ub, sa, sb, ur, sr;
    longint smax, smin;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (!s) begin
      ur     = ua + ub;
      e.cout = (ur >= (longint'(1) <<< W));
      sr     = sa + sb;
    end else begin
      ur     = ua - ub;
      e.cout = (ua >= ub);
      sr     = sa - sb;
    end
    e.sum = W'(ur);
    e.ovf = (sr > smax) || (sr < smin);
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      chk("done_single_pulse", W'(prev_done), W'(0));
      if (q.size() == 0) begin
        chk("unexpected_done", W'(1), W'(0));
      end else begin
        e = q.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", W'(cout), W'(e.cout));
        chk("overflow", W'(overflow), W'(e.ovf));
        chk("latency", W'(cyc - e.cyc), W'(LAT));
      end
    end
    prev_done = done;
  end

  // Drive one request in the first cycle the DUT is idle; returns that cycle.
  task automatic issue(input bit [W-1:0] a, input bit [W-1:0] b, input bit s,
                       input bit push, output int c);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("idle_timeout", W'(1), W'(0));
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
    c     = cyc;
    if (push) begin
      e     = model(a, b, s);
      e.cyc = c;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs: must not disturb the accepted operation.
    a_in  = $urandom;
    b_in  = $urandom;
    sub   = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("drain_timeout", W'(1), W'(0));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int c0, c1;
    bit [W-1:0] dir_a [5] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h80000000};
    bit [W-1:0] dir_b [5] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
    bit         dir_s [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_sum", sum, W'(0));
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_overflow", W'(overflow), W'(0));

    // Directed carry / borrow / overflow corners.
    for (int i = 0; i < 5; i++) begin
      issue(dir_a[i], dir_b[i], dir_s[i], 1'b1, c0);
      drain();
    end

    // start while RUN is ignored.
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b1, c0);
    a_in  = 32'h11111111;
    b_in  = 32'h22222222;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_during_run", W'(busy), W'(1));
    drain();
    repeat (6) @(negedge clk);

    // Reset on the second RUN cycle aborts without a done pulse.
    issue(32'hDEADBEEF, 32'h01020304, 1'b0, 1'b0, c0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_sum", sum, W'(0));
    chk("abort_cout", W'(cout), W'(0));
    chk("abort_overflow", W'(overflow), W'(0));
    repeat (6) @(negedge clk);
    issue(32'h00000001, 32'h00000001, 1'b0, 1'b1, c0);
    drain();

    // Back-to-back: second start in the first IDLE cycle after done.
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, c0);
    issue(32'h00000003, 32'h00000004, 1'b0, 1'b1, c1);
    chk("b2b_spacing", W'(c1 - c0), W'(WORDS + 2));
    drain();

    // Randomized traffic, mostly back-to-back.
    for (int i = 0; i < 40; i++) begin
      bit [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = {1'b0, ra[W-2:0]};
        1: rb = ~ra;
        2: rb = ra;
        default: ;
      endcase
      issue(ra, rb, 1'($urandom), 1'b1, c0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();
    chk("queue_empty", W'(q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
